// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream packet demultiplexer.
package axis_pkg;

  // Packet-level routing state: waiting for a head beat, forwarding, or discarding.
  typedef enum logic [1:0] {
    ST_HEAD = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } demux_state_t;

  // Default tuser bit position of the destination bitmap.
  localparam int DEST_LSB_DEFAULT = 24;

endpackage

// File: rtl/axis_reg_slice.sv
// One-beat AXI-Stream output register with same-cycle drain and reload.
module axis_reg_slice #(
  parameter int DATA_W = 512,
  parameter int USER_W = 256
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                load,
  input  logic [DATA_W-1:0]   in_tdata,
  input  logic [DATA_W/8-1:0] in_tkeep,
  input  logic [USER_W-1:0]   in_tuser,
  input  logic                in_tlast,
  output logic                free,
  output logic [DATA_W-1:0]   m_tdata,
  output logic [DATA_W/8-1:0] m_tkeep,
  output logic [USER_W-1:0]   m_tuser,
  output logic                m_tlast,
  output logic                m_tvalid,
  input  logic                m_tready
);

  logic                vld_p1;
  logic [DATA_W-1:0]   tdata_p1;
  logic [DATA_W/8-1:0] tkeep_p1;
  logic [USER_W-1:0]   tuser_p1;
  logic                tlast_p1;

  // The register can take a new beat when empty or when its current beat leaves this cycle.
  assign free = !vld_p1 || m_tready;

  // Occupancy flag: a reload on a draining cycle keeps valid high with no bubble.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      vld_p1 <= 1'b0;
    end else if (load) begin
      vld_p1 <= 1'b1;
    end else if (m_tready) begin
      vld_p1 <= 1'b0;
    end
  end

  // Payload captured only on load, so it is held stable while stalled; not reset.
  always_ff @(posedge aclk) begin
    if (load) begin
      tdata_p1 <= in_tdata;
      tkeep_p1 <= in_tkeep;
      tuser_p1 <= in_tuser;
      tlast_p1 <= in_tlast;
    end
  end

  assign m_tvalid = vld_p1;
  assign m_tdata  = tdata_p1;
  assign m_tkeep  = tkeep_p1;
  assign m_tuser  = tuser_p1;
  assign m_tlast  = tlast_p1;

endmodule

// File: rtl/axis_pkt_demux.sv
// AXI-Stream packet demultiplexer: routes each packet to the ports named by a
// tuser bitmap taken from its head beat; multicast to several ports, drop on empty bitmap.
module axis_pkt_demux
  import axis_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH  = 512,
  parameter int AXIS_TUSER_WIDTH = 256,
  parameter int M_INTF_NUM       = 7,
  parameter int DEST_LSB         = DEST_LSB_DEFAULT
) (
  input  logic                                      aclk,
  input  logic                                      aresetn,
  input  logic [AXIS_DATA_WIDTH-1:0]                s_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0]              s_axis_tkeep,
  input  logic [AXIS_TUSER_WIDTH-1:0]               s_axis_tuser,
  input  logic                                      s_axis_tvalid,
  input  logic                                      s_axis_tlast,
  output logic                                      s_axis_tready,
  output logic [M_INTF_NUM*AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [M_INTF_NUM*AXIS_DATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic [M_INTF_NUM*AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
  output logic [M_INTF_NUM-1:0]                     m_axis_tvalid,
  output logic [M_INTF_NUM-1:0]                     m_axis_tlast,
  input  logic [M_INTF_NUM-1:0]                     m_axis_tready,
  output logic [31:0]                               drop_count
);

  localparam int KEEP_W = AXIS_DATA_WIDTH / 8;

  demux_state_t          state;
  logic [M_INTF_NUM-1:0] sel;
  logic [M_INTF_NUM-1:0] dest;
  logic [M_INTF_NUM-1:0] active;
  logic [M_INTF_NUM-1:0] free;
  logic [M_INTF_NUM-1:0] load;
  logic                  dest_nz;
  logic                  all_free;
  logic                  fwd_mode;
  logic                  accept;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Only M_INTF_NUM bitmap bits are taken, so bits beyond the port count never route.
  assign dest     = s_axis_tuser[DEST_LSB +: M_INTF_NUM];
  assign dest_nz  = |dest;
  assign active   = (state == ST_HEAD) ? dest : sel;
  assign all_free = &(free | ~active);
  assign fwd_mode = (state == ST_FWD) || ((state == ST_HEAD) && dest_nz);
  assign accept   = s_axis_tvalid && s_axis_tready;
  assign load     = (accept && fwd_mode) ? active : '0;

  // Upstream ready: held low in reset, always open when discarding, else gated by selected ports.
  always_comb begin
    s_axis_tready = 1'b0;
    if (aresetn) begin
      case (state)
        ST_HEAD: s_axis_tready = dest_nz ? all_free : 1'b1;
        ST_FWD:  s_axis_tready = all_free;
        ST_DROP: s_axis_tready = 1'b1;
        default: s_axis_tready = 1'b0;
      endcase
    end
  end

  // Packet FSM: latch the head bitmap, count dropped packets, and return to HEAD on tlast.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= ST_HEAD;
      sel        <= '0;
      drop_count <= '0;
    end else if (accept) begin
      case (state)
        ST_HEAD: begin
          if (dest_nz) begin
            sel <= dest;
            if (!s_axis_tlast) state <= ST_FWD;
          end else begin
            drop_count <= sat_inc(drop_count);
            if (!s_axis_tlast) state <= ST_DROP;
          end
        end
        ST_FWD, ST_DROP: begin
          if (s_axis_tlast) state <= ST_HEAD;
        end
        default: state <= ST_HEAD;
      endcase
    end
  end

  for (genvar i = 0; i < M_INTF_NUM; i++) begin : g_port
    axis_reg_slice #(
      .DATA_W (AXIS_DATA_WIDTH),
      .USER_W (AXIS_TUSER_WIDTH)
    ) u_slice (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .load     (load[i]),
      .in_tdata (s_axis_tdata),
      .in_tkeep (s_axis_tkeep),
      .in_tuser (s_axis_tuser),
      .in_tlast (s_axis_tlast),
      .free     (free[i]),
      .m_tdata  (m_axis_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH]),
      .m_tkeep  (m_axis_tkeep[i*KEEP_W +: KEEP_W]),
      .m_tuser  (m_axis_tuser[i*AXIS_TUSER_WIDTH +: AXIS_TUSER_WIDTH]),
      .m_tlast  (m_axis_tlast[i]),
      .m_tvalid (m_axis_tvalid[i]),
      .m_tready (m_axis_tready[i])
    );
  end

endmodule

// File: tb/tb_axis_pkt_demux.sv
// Directed bench for axis_pkt_demux: a 7-port instance for routing, stall and drop,
// and a 4-port instance sharing the slave stream for out-of-range bitmap bits.
module tb_axis_pkt_demux;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep;
  logic [15:0] s_tuser;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic        s_tready2;

  logic [7*32-1:0] m_tdata;
  logic [7*4-1:0]  m_tkeep;
  logic [7*16-1:0] m_tuser;
  logic [6:0]      m_tvalid;
  logic [6:0]      m_tlast;
  logic [6:0]      m_tready;
  logic [31:0]     drop_cnt;

  logic [4*32-1:0] m2_tdata;
  logic [4*4-1:0]  m2_tkeep;
  logic [4*16-1:0] m2_tuser;
  logic [3:0]      m2_tvalid;
  logic [3:0]      m2_tlast;
  logic [3:0]      m2_tready;
  logic [31:0]     drop_cnt2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 aclk = ~aclk;

  axis_pkt_demux #(
    .AXIS_DATA_WIDTH (32), .AXIS_TUSER_WIDTH (16), .M_INTF_NUM (7), .DEST_LSB (4)
  ) dut (
    .aclk (aclk), .aresetn (aresetn),
    .s_axis_tdata (s_tdata), .s_axis_tkeep (s_tkeep), .s_axis_tuser (s_tuser),
    .s_axis_tvalid (s_tvalid), .s_axis_tlast (s_tlast), .s_axis_tready (s_tready),
    .m_axis_tdata (m_tdata), .m_axis_tkeep (m_tkeep), .m_axis_tuser (m_tuser),
    .m_axis_tvalid (m_tvalid), .m_axis_tlast (m_tlast), .m_axis_tready (m_tready),
    .drop_count (drop_cnt)
  );

  axis_pkt_demux #(
    .AXIS_DATA_WIDTH (32), .AXIS_TUSER_WIDTH (16), .M_INTF_NUM (4), .DEST_LSB (4)
  ) dut4 (
    .aclk (aclk), .aresetn (aresetn),
    .s_axis_tdata (s_tdata), .s_axis_tkeep (s_tkeep), .s_axis_tuser (s_tuser),
    .s_axis_tvalid (s_tvalid), .s_axis_tlast (s_tlast), .s_axis_tready (s_tready2),
    .m_axis_tdata (m2_tdata), .m_axis_tkeep (m2_tkeep), .m_axis_tuser (m2_tuser),
    .m_axis_tvalid (m2_tvalid), .m_axis_tlast (m2_tlast), .m_axis_tready (m2_tready),
    .drop_count (drop_cnt2)
  );

  typedef struct {
    logic        sv;
    logic        sl;
    logic [6:0]  dest;
    logic [31:0] data;
    logic [6:0]  mrdy;
    logic        e_srdy;
    logic [6:0]  e_mv;
    logic [6:0]  e_ml;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[25];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic l, input logic [6:0] d, input logic [31:0] dat);
    s_tvalid = v;
    s_tlast  = l;
    s_tuser  = {5'b0, d, 4'b0};
    s_tdata  = dat;
    s_tkeep  = 4'hF;
  endtask

  task automatic next_cycle();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    // unicast to port 2, 3 beats; later beats carry a bogus bitmap that must be ignored
    tbl[0]  = '{1'b1, 1'b0, 7'h04, 32'hA000_0001, 7'h7F, 1'b1, 7'h00, 7'h00, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 7'h01, 32'hA000_0002, 7'h7F, 1'b1, 7'h04, 7'h00, 32'hA000_0001};
    tbl[2]  = '{1'b1, 1'b1, 7'h01, 32'hA000_0003, 7'h7F, 1'b1, 7'h04, 7'h00, 32'hA000_0002};
    tbl[3]  = '{1'b0, 1'b0, 7'h00, 32'h0,         7'h7F, 1'b1, 7'h04, 7'h04, 32'hA000_0003};
    tbl[4]  = '{1'b0, 1'b0, 7'h00, 32'h0,         7'h7F, 1'b1, 7'h00, 7'h00, 32'h0};
    // back-to-back single-beat packets to ports 0,1,0,1
    tbl[5]  = '{1'b1, 1'b1, 7'h01, 32'hB000_0000, 7'h7F, 1'b1, 7'h00, 7'h00, 32'h0};
    tbl[6]  = '{1'b1, 1'b1, 7'h02, 32'hB000_0001, 7'h7F, 1'b1, 7'h01, 7'h01, 32'hB000_0000};
    tbl[7]  = '{1'b1, 1'b1, 7'h01, 32'hB000_0002, 7'h7F, 1'b1, 7'h02, 7'h02, 32'hB000_0001};
    tbl[8]  = '{1'b1, 1'b1, 7'h02, 32'hB000_0003, 7'h7F, 1'b1, 7'h01, 7'h01, 32'hB000_0002};
    tbl[9]  = '{1'b0, 1'b0, 7'h00, 32'h0,         7'h7F, 1'b1, 7'h02, 7'h02, 32'hB000_0003};
    tbl[10] = '{1'b0, 1'b0, 7'h00, 32'h0,         7'h7F, 1'b1, 7'h00, 7'h00, 32'h0};
    // dropped 2-beat packet (zero bitmap), then 2-beat packet to port 6
    tbl[11] = '{1'b1, 1'b0, 7'h00, 32'hC000_0000, 7'h7F, 1'b1, 7'h00, 7'h00, 32'h0};
    tbl[12] = '{1'b1, 1'b1, 7'h40, 32'hC000_0001, 7'h7F, 1'b1, 7'h00, 7'h00, 32'h0};
    tbl[13] = '{1'b1, 1'b0, 7'h40, 32'hD000_0000, 7'h7F, 1'b1, 7'h00, 7'h00, 32'h0};
    tbl[14] = '{1'b1, 1'b1, 7'h00, 32'hD000_0001, 7'h7F, 1'b1, 7'h40, 7'h00, 32'hD000_0000};
    tbl[15] = '{1'b0, 1'b0, 7'h00, 32'h0,         7'h7F, 1'b1, 7'h40, 7'h40, 32'hD000_0001};
    tbl[16] = '{1'b0, 1'b0, 7'h00, 32'h0,         7'h7F, 1'b1, 7'h00, 7'h00, 32'h0};
    // multicast to ports 0,1 with port 1 stalled for 4 cycles
    tbl[17] = '{1'b1, 1'b0, 7'h03, 32'hE000_0000, 7'h7F, 1'b1, 7'h00, 7'h00, 32'h0};
    tbl[18] = '{1'b1, 1'b1, 7'h00, 32'hE000_0001, 7'h7D, 1'b0, 7'h03, 7'h00, 32'hE000_0000};
    tbl[19] = '{1'b1, 1'b1, 7'h00, 32'hE000_0001, 7'h7D, 1'b0, 7'h02, 7'h00, 32'hE000_0000};
    tbl[20] = '{1'b1, 1'b1, 7'h00, 32'hE000_0001, 7'h7D, 1'b0, 7'h02, 7'h00, 32'hE000_0000};
    tbl[21] = '{1'b1, 1'b1, 7'h00, 32'hE000_0001, 7'h7D, 1'b0, 7'h02, 7'h00, 32'hE000_0000};
    tbl[22] = '{1'b1, 1'b1, 7'h00, 32'hE000_0001, 7'h7F, 1'b1, 7'h02, 7'h00, 32'hE000_0000};
    tbl[23] = '{1'b0, 1'b0, 7'h00, 32'h0,         7'h7F, 1'b1, 7'h03, 7'h03, 32'hE000_0001};
    tbl[24] = '{1'b0, 1'b0, 7'h00, 32'h0,         7'h7F, 1'b1, 7'h00, 7'h00, 32'h0};

    aresetn   = 1'b0;
    m_tready  = 7'h7F;
    m2_tready = 4'hF;
    drive(1'b0, 1'b0, 7'h00, 32'h0);

    // reset state
    @(negedge aclk);
    repeat (2) next_cycle();
    chk("rst s_tready", {63'b0, s_tready}, 64'd0);
    chk("rst s_tready4", {63'b0, s_tready2}, 64'd0);
    chk("rst m_tvalid", {57'b0, m_tvalid}, 64'd0);
    chk("rst drop_count", {32'b0, drop_cnt}, 64'd0);
    aresetn = 1'b1;

    // table-driven cycles
    for (int k = 0; k < 25; k++) begin
      drive(tbl[k].sv, tbl[k].sl, tbl[k].dest, tbl[k].data);
      m_tready = tbl[k].mrdy;
      @(negedge aclk);
      chk($sformatf("v%0d s_tready", k), {63'b0, s_tready}, {63'b0, tbl[k].e_srdy});
      chk($sformatf("v%0d m_tvalid", k), {57'b0, m_tvalid}, {57'b0, tbl[k].e_mv});
      chk($sformatf("v%0d m_tlast", k), {57'b0, m_tvalid & m_tlast}, {57'b0, tbl[k].e_ml});
      for (int p = 0; p < 7; p++) begin
        if (tbl[k].e_mv[p])
          chk($sformatf("v%0d port%0d tdata", k, p), {32'b0, m_tdata[p*32 +: 32]}, {32'b0, tbl[k].e_data});
      end
      next_cycle();
    end
    chk("drop_count after burst", {32'b0, drop_cnt}, 64'd1);

    // mid-packet reset
    m_tready = 7'h7F;
    drive(1'b1, 1'b0, 7'h04, 32'hF000_0000);
    @(negedge aclk);
    chk("mrst head s_tready", {63'b0, s_tready}, 64'd1);
    next_cycle();
    aresetn = 1'b0;
    drive(1'b0, 1'b0, 7'h00, 32'h0);
    @(negedge aclk);
    chk("mrst s_tready low", {63'b0, s_tready}, 64'd0);
    chk("mrst port2 before edge", {57'b0, m_tvalid}, 64'h04);
    next_cycle();
    aresetn = 1'b1;
    drive(1'b1, 1'b1, 7'h20, 32'h6000_0000);
    @(negedge aclk);
    chk("mrst m_tvalid cleared", {57'b0, m_tvalid}, 64'd0);
    chk("mrst drop_count cleared", {32'b0, drop_cnt}, 64'd0);
    chk("mrst new head s_tready", {63'b0, s_tready}, 64'd1);
    next_cycle();
    drive(1'b0, 1'b0, 7'h00, 32'h0);
    @(negedge aclk);
    chk("mrst new head port5 valid", {57'b0, m_tvalid}, 64'h20);
    chk("mrst new head port5 last", {57'b0, m_tvalid & m_tlast}, 64'h20);
    chk("mrst new head port5 tdata", {32'b0, m_tdata[5*32 +: 32]}, 64'h6000_0000);
    next_cycle();

    // out-of-range bitmap bits on the 4-port instance
    aresetn = 1'b0;
    next_cycle();
    aresetn = 1'b1;
    drive(1'b1, 1'b0, 7'h70, 32'h7000_0000);
    @(negedge aclk);
    chk("oor head s_tready4", {63'b0, s_tready2}, 64'd1);
    chk("oor drop_count4 before", {32'b0, drop_cnt2}, 64'd0);
    next_cycle();
    drive(1'b1, 1'b1, 7'h70, 32'h7000_0001);
    @(negedge aclk);
    chk("oor m_tvalid4", {60'b0, m2_tvalid}, 64'd0);
    chk("oor drop_count4", {32'b0, drop_cnt2}, 64'd1);
    chk("oor drop s_tready4", {63'b0, s_tready2}, 64'd1);
    next_cycle();
    drive(1'b1, 1'b1, 7'h08, 32'h7100_0000);
    @(negedge aclk);
    chk("oor tail m_tvalid4", {60'b0, m2_tvalid}, 64'd0);
    next_cycle();
    drive(1'b0, 1'b0, 7'h00, 32'h0);
    @(negedge aclk);
    chk("in-range port3 valid4", {60'b0, m2_tvalid}, 64'h8);
    chk("in-range port3 tdata4", {32'b0, m2_tdata[3*32 +: 32]}, 64'h7100_0000);
    chk("drop_count4 final", {32'b0, drop_cnt2}, 64'd1);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
